multichannel_adc_ctrl: RTL and testbench

Parametrised comparator-based ADC controller driving an external R2R DAC and analog input multiplexer. It is the next generation of our single-channel ramp ADC. Each conversion runs in either single-slope ramp mode or successive-approximation (SAR) mode on a selectable channel, using a start/busy/data_valid handshake. It sits between the board's R2R ladder, comparator and analog mux on one side and the display/readout logic on the other.

---
 rtl/multichannel_adc_ctrl_if.sv | 18 +
 rtl/multichannel_adc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_multichannel_adc_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multichannel_adc_ctrl_if.sv
// Request/result handshake between multichannel_adc_ctrl and the readout logic.
interface multichannel_adc_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic             start;
  logic             mode;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;
  logic             data_valid;
  logic [WIDTH-1:0] result;
  logic [CH_W-1:0]  result_ch;

  modport master (output start, mode, ch_sel,
                  input  busy, data_valid, result, result_ch);
  modport slave  (input  start, mode, ch_sel,
                  output busy, data_valid, result, result_ch);
endinterface

// File: rtl/multichannel_adc_ctrl.sv
// Ramp/SAR comparator ADC controller for an R2R DAC and analog mux.
// Define ADC_AVG_EN to average four back-to-back conversions per start.
module multichannel_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 100,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  multichannel_adc_ctrl_if.slave bus,
  input  logic                   comparator,
  output logic [WIDTH-1:0]       dac_out,
  output logic [CH_W-1:0]        mux_sel
);

  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must be within 2..16");
  end

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DECIDE, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [WIDTH-1:0] r_code, w_code_nxt;
  logic [WIDTH-1:0] r_mask, w_mask_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_mode, w_mode_nxt;
  logic [CH_W-1:0]  r_mux, w_mux_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CH_W-1:0]  r_rch, w_rch_nxt;
  logic             w_comp_s;
  logic             w_pass_done;
  logic [WIDTH-1:0] w_pass_res;
  logic [WIDTH-1:0] w_sar_code;
`ifdef ADC_AVG_EN
  logic [WIDTH+1:0] r_acc, w_acc_nxt, w_sum;
  logic [1:0]       r_pass, w_pass_nxt;
`endif

  assign w_comp_s = r_sync[1];

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_mask_nxt   = r_mask;
    w_cnt_nxt    = r_cnt;
    w_mode_nxt   = r_mode;
    w_mux_nxt    = r_mux;
    w_result_nxt = r_result;
    w_rch_nxt    = r_rch;
    w_pass_done  = 1'b0;
    w_pass_res   = '0;
    w_sar_code   = w_comp_s ? r_code : (r_code & ~r_mask);
`ifdef ADC_AVG_EN
    w_acc_nxt    = r_acc;
    w_pass_nxt   = r_pass;
    w_sum        = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mode_nxt  = bus.mode;
          w_mux_nxt   = bus.ch_sel;
          w_code_nxt  = bus.mode ? MSB : '0;
          w_mask_nxt  = MSB;
          w_cnt_nxt   = SETTLE_LOAD;
          w_state_nxt = S_SETTLE;
`ifdef ADC_AVG_EN
          w_acc_nxt   = '0;
          w_pass_nxt  = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = S_DECIDE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_DECIDE: begin
        w_cnt_nxt   = SETTLE_LOAD;
        w_state_nxt = S_SETTLE;
        if (!r_mode) begin
          if (!w_comp_s) begin
            w_pass_done = 1'b1;
            w_pass_res  = (r_code == '0) ? '0 : r_code - WIDTH'(1);
          end else if (r_code == MAX) begin
            w_pass_done = 1'b1;
            w_pass_res  = MAX;
          end else begin
            w_code_nxt  = r_code + WIDTH'(1);
          end
        end else if (r_mask[0]) begin
          w_pass_done = 1'b1;
          w_pass_res  = w_sar_code;
        end else begin
          w_code_nxt  = w_sar_code | (r_mask >> 1);
          w_mask_nxt  = r_mask >> 1;
        end
        if (w_pass_done) begin
`ifdef ADC_AVG_EN
          // Passes 1-3 restart straight into SETTLE so DONE is paid only once.
          w_sum = r_acc + {2'b00, w_pass_res};
          if (r_pass == 2'd3) begin
            w_state_nxt  = S_DONE;
            w_code_nxt   = '0;
            w_result_nxt = WIDTH'((w_sum + (WIDTH+2)'(2)) >> 2);
            w_rch_nxt    = r_mux;
          end else begin
            w_acc_nxt    = w_sum;
            w_pass_nxt   = r_pass + 2'd1;
            w_code_nxt   = r_mode ? MSB : '0;
            w_mask_nxt   = MSB;
          end
`else
          w_state_nxt  = S_DONE;
          w_code_nxt   = '0;
          w_result_nxt = w_pass_res;
          w_rch_nxt    = r_mux;
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sync   <= '0;
      r_code   <= '0;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_mux    <= '0;
      r_result <= '0;
      r_rch    <= '0;
`ifdef ADC_AVG_EN
      r_acc    <= '0;
      r_pass   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sync   <= {r_sync[0], comparator};
      r_code   <= w_code_nxt;
      r_mask   <= w_mask_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode   <= w_mode_nxt;
      r_mux    <= w_mux_nxt;
      r_result <= w_result_nxt;
      r_rch    <= w_rch_nxt;
`ifdef ADC_AVG_EN
      r_acc    <= w_acc_nxt;
      r_pass   <= w_pass_nxt;
`endif
    end
  end

  assign bus.busy       = (r_state == S_SETTLE) || (r_state == S_DECIDE);
  assign bus.data_valid = (r_state == S_DONE);
  assign bus.result     = r_result;
  assign bus.result_ch  = r_rch;
  assign dac_out        = r_code;
  assign mux_sel        = r_mux;

endmodule

// File: tb/tb_multichannel_adc_ctrl.sv
// Directed bench for multichannel_adc_ctrl with a per-cycle reference model.
// Builds with or without ADC_AVG_EN.
module tb_multichannel_adc_ctrl;
  localparam int W    = 8;
  localparam int NCH  = 4;
  localparam int SC   = 4;
  localparam int CHW  = 2;
  localparam int STEP = SC + 1;
  localparam int unsigned MAXV = (1 << W) - 1;
`ifdef ADC_AVG_EN
  localparam int unsigned PASSES = 4;
  localparam int unsigned N_SAR = 161, N_R3 = 101, N_RFF = 5121, N_F0 = 21, N_R0 = 41;
`else
  localparam int unsigned PASSES = 1;
  localparam int unsigned N_SAR = 41, N_R3 = 26, N_RFF = 1281, N_F0 = 6, N_R0 = 11;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic comparator;
  logic [W-1:0]   dac_out;
  logic [CHW-1:0] mux_sel;

  multichannel_adc_ctrl_if #(.WIDTH(W), .CH_W(CHW)) bus ();

  multichannel_adc_ctrl #(.WIDTH(W), .NUM_CH(NCH), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .comparator(comparator), .dac_out(dac_out), .mux_sel(mux_sel)
  );

  always #5 clk = ~clk;

  int unsigned vin_ch [NCH];
  int unsigned plan_pv [4];
  logic force0 = 1'b0;

  assign comparator = force0 ? 1'b0 : (vin_ch[mux_sel] >= 32'(dac_out));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conversion outcome from the transfer rule: largest code with Vdac <= Vin.
  function automatic int unsigned pass_code(input logic f0, input int unsigned v);
    if (f0) return 0;
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int unsigned pass_steps(input logic md, input logic f0, input int unsigned v);
    if (md) return W;
    if (f0) return 1;
    return (v + 2 < MAXV + 1) ? v + 2 : MAXV + 1;
  endfunction

  function automatic int unsigned pred_res(input logic f0);
    int unsigned sum = 0;
    for (int unsigned k = 0; k < PASSES; k++) sum += pass_code(f0, plan_pv[k]);
    return (sum + PASSES / 2) / PASSES;
  endfunction

  function automatic int unsigned pred_lat(input logic md, input logic f0);
    int unsigned lat = 1;
    for (int unsigned k = 0; k < PASSES; k++) lat += pass_steps(md, f0, plan_pv[k]) * STEP;
    return lat;
  endfunction

  logic           m_busy = 1'b0;
  logic           m_dv = 1'b0;
  logic [W-1:0]   m_result = '0;
  logic [CHW-1:0] m_rch = '0;
  logic [CHW-1:0] m_mux = '0;
  int unsigned    m_cnt = 0;
  int unsigned    m_pend = 0;
  bit             chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_dv <= 1'b0; m_result <= '0; m_rch <= '0; m_mux <= '0; m_cnt <= 0;
    end else begin
      m_dv <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_dv <= 1'b1; m_result <= W'(m_pend); m_rch <= m_mux;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (!m_dv && bus.start) begin
        m_busy <= 1'b1;
        m_mux  <= bus.ch_sel;
        m_pend <= pred_res(force0);
        m_cnt  <= pred_lat(bus.mode, force0) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.busy", 32'(bus.busy), 32'(m_busy));
      check("cyc.data_valid", 32'(bus.data_valid), 32'(m_dv));
      check("cyc.result", 32'(bus.result), 32'(m_result));
      check("cyc.result_ch", 32'(bus.result_ch), 32'(m_rch));
      check("cyc.mux_sel", 32'(mux_sel), 32'(m_mux));
      if (!m_busy) check("cyc.dac_idle", 32'(dac_out), 32'h0);
    end
  end

  task automatic run(input string tag, input logic md, input int unsigned ch,
                     input int unsigned v0, input int unsigned v1,
                     input int unsigned v2, input int unsigned v3,
                     input logic f0, input int unsigned glitch_at,
                     input int unsigned exp_n, input int unsigned exp_res);
    int unsigned n;
    int unsigned period;
    bit seen;
    period = W * STEP;
    plan_pv = '{v0, v1, v2, v3};
    force0 = f0;
    vin_ch[ch] = v0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = md; bus.ch_sel = CHW'(ch);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    check({tag, ".mux_t1"}, 32'(mux_sel), ch);
    check({tag, ".dac_t1"}, 32'(dac_out), md ? 32'h80 : 32'h0);
    seen = 1'b0;
    while (!seen && n < exp_n + 50) begin
      if (bus.data_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
        bus.start = (n == glitch_at);
        if (n == glitch_at) begin
          bus.mode = ~md; bus.ch_sel = CHW'(ch ^ 1);
        end
        if (md && (n % period == 1) && (n / period < 4)) vin_ch[ch] = plan_pv[n / period];
      end
    end
    check({tag, ".latency"}, seen ? n : 0, exp_n);
    check({tag, ".result"}, 32'(bus.result), exp_res);
    check({tag, ".result_ch"}, 32'(bus.result_ch), ch);
  endtask

  bit dv_seen;

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.ch_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) vin_ch[i] = 0;
    plan_pv = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.data_valid", 32'(bus.data_valid), 0);
    check("reset.dac_out", 32'(dac_out), 0);
    check("reset.mux_sel", 32'(mux_sel), 0);
    check("reset.result", 32'(bus.result), 0);
    check("reset.result_ch", 32'(bus.result_ch), 0);
    reset = 1'b0;

    run("sar5a", 1'b1, 2, 'h5A, 'h5A, 'h5A, 'h5A, 1'b0, 0, N_SAR, 'h5A);
    bus.start = 1'b1; bus.mode = 1'b0; bus.ch_sel = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_start.busy", 32'(bus.busy), 0);
    check("done_start.mux_hold", 32'(mux_sel), 2);

    run("ramp3", 1'b0, 0, 3, 3, 3, 3, 1'b0, 0, N_R3, 3);
    run("rampff", 1'b0, 3, 'hFF, 'hFF, 'hFF, 'hFF, 1'b0, 0, N_RFF, 'hFF);
    run("force0", 1'b0, 1, 'h80, 'h80, 'h80, 'h80, 1'b1, 0, N_F0, 0);
    run("ramp0", 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, N_R0, 0);
    run("sar00", 1'b1, 3, 0, 0, 0, 0, 1'b0, 0, N_SAR, 0);
    run("sarff", 1'b1, 0, 'hFF, 'hFF, 'hFF, 'hFF, 1'b0, 0, N_SAR, 'hFF);
    run("glitch", 1'b1, 2, 'h5A, 'h5A, 'h5A, 'h5A, 1'b0, 10, N_SAR, 'h5A);

    plan_pv = '{'h33, 'h33, 'h33, 'h33};
    vin_ch[1] = 'h33;
    force0 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1; bus.ch_sel = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.data_valid", 32'(bus.data_valid), 0);
    check("rst.dac_out", 32'(dac_out), 0);
    check("rst.mux_sel", 32'(mux_sel), 0);
    check("rst.result", 32'(bus.result), 0);
    check("rst.result_ch", 32'(bus.result_ch), 0);
    dv_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.data_valid) dv_seen = 1'b1;
    end
    check("rst.no_dv", 32'(dv_seen), 0);
    run("after_rst", 1'b1, 1, 'h33, 'h33, 'h33, 'h33, 1'b0, 0, N_SAR, 'h33);

`ifdef ADC_AVG_EN
    run("avg", 1'b1, 2, 'h40, 'h41, 'h41, 'h42, 1'b0, 0, 161, 'h41);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
